// File: rtl/pcm_pdm_modulator.sv
// PCM-to-PDM modulator: input FIFO, zero-order hold over RATIO bits, error-feedback sigma-delta loop.
// Define PDM_PCM_CONVERTER_SECOND_ORDER_EN to add the second integrator.
module pcm_pdm_modulator #(
    parameter int PDM_PCM_CONVERTER_DATA_WIDTH          = 16,
    parameter int PDM_PCM_CONVERTER_INTERPOLATION_RATIO = 16,
    parameter int PDM_PCM_CONVERTER_FIFO_DEPTH          = 4
) (
    input  logic                                    clock_i,
    input  logic                                    reset_n_i,
    input  logic [PDM_PCM_CONVERTER_DATA_WIDTH-1:0] pcm_data_i,
    input  logic                                    pcm_valid_i,
    output logic                                    pcm_ready_o,
    output logic                                    pdm_data_o,
    output logic                                    pdm_valid_o,
    input  logic                                    pdm_ready_i,
    input  logic                                    enable_i,
    output logic                                    busy_o,
    output logic                                    overflow_o,
    output logic                                    underflow_o
);
    localparam int W   = PDM_PCM_CONVERTER_DATA_WIDTH;
    localparam int R   = PDM_PCM_CONVERTER_INTERPOLATION_RATIO;
    localparam int D   = PDM_PCM_CONVERTER_FIFO_DEPTH;
    localparam int AW  = $clog2(D);
    localparam int CW  = $clog2(R);
    localparam int I1W = W + 2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic signed [I1W:0]   FS1    = {{(I1W + 1 - W){1'b0}}, 1'b1, {(W - 1){1'b0}}};
    localparam logic signed [I1W-1:0] I1_MIN = {1'b1, {(I1W - 1){1'b0}}};
    localparam logic signed [I1W-1:0] I1_MAX = {1'b0, {(I1W - 1){1'b1}}};

    logic [W-1:0]          mem_q [D];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic [0:0]            state_q, state_d;
    logic signed [W-1:0]   sample_q, sample_d;
    logic [CW-1:0]         step_cnt_q, step_cnt_d;
    logic signed [I1W-1:0] i1_q, i1_d, i1_new;
    logic                  bit_q, bit_d, bit_new;
    logic                  ovf_q, ovf_d, unf_q, unf_d;

    logic                  fifo_empty, fifo_full, push, pop, step, last;
    logic signed [I1W:0]   sum1;
    logic                  sat1, sat_any;

`ifdef PDM_PCM_CONVERTER_SECOND_ORDER_EN
    localparam int I2W = W + 4;
    localparam logic signed [I2W:0]   FS2    = {{(I2W + 1 - W){1'b0}}, 1'b1, {(W - 1){1'b0}}};
    localparam logic signed [I2W-1:0] I2_MIN = {1'b1, {(I2W - 1){1'b0}}};
    localparam logic signed [I2W-1:0] I2_MAX = {1'b0, {(I2W - 1){1'b1}}};
    logic signed [I2W-1:0] i2_q, i2_d, i2_new;
    logic signed [I2W:0]   sum2;
    logic                  sat2;
`endif

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == (AW + 1)'(D));
    assign pcm_ready_o = enable_i && !fifo_full;
    assign push        = pcm_valid_i && pcm_ready_o;
    assign pdm_valid_o = enable_i && (state_q == ST_RUN);
    assign step        = pdm_valid_o && pdm_ready_i;
    assign last        = (step_cnt_q == CW'(R - 1));
    assign pop         = enable_i && !fifo_empty && ((state_q == ST_IDLE) || (step && last));

    assign pdm_data_o  = bit_q;
    assign busy_o      = (state_q == ST_RUN) || !fifo_empty;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

    // One loop step; the wide sum can only escape the integrator range by one bit, so
    // a disagreement between the top two bits flags the clamp.
    always_comb begin
        sum1   = (I1W + 1)'(i1_q) + (I1W + 1)'(sample_q) - (bit_q ? FS1 : -FS1);
        sat1   = (sum1[I1W] != sum1[I1W-1]);
        i1_new = sat1 ? (sum1[I1W] ? I1_MIN : I1_MAX) : sum1[I1W-1:0];
`ifdef PDM_PCM_CONVERTER_SECOND_ORDER_EN
        sum2    = (I2W + 1)'(i2_q) + (I2W + 1)'(i1_new) - (bit_q ? FS2 : -FS2);
        sat2    = (sum2[I2W] != sum2[I2W-1]);
        i2_new  = sat2 ? (sum2[I2W] ? I2_MIN : I2_MAX) : sum2[I2W-1:0];
        bit_new = !i2_new[I2W-1];
        sat_any = sat1 || sat2;
`else
        bit_new = !i1_new[I1W-1];
        sat_any = sat1;
`endif
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        sample_d   = sample_q;
        step_cnt_d = step_cnt_q;
        i1_d       = i1_q;
        bit_d      = bit_q;
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
`ifdef PDM_PCM_CONVERTER_SECOND_ORDER_EN
        i2_d       = i2_q;
`endif
        if (!enable_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            state_d    = ST_IDLE;
            sample_d   = '0;
            step_cnt_d = '0;
            i1_d       = '0;
            bit_d      = 1'b0;
`ifdef PDM_PCM_CONVERTER_SECOND_ORDER_EN
            i2_d       = '0;
`endif
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase

            if (state_q == ST_IDLE) begin
                if (!fifo_empty) begin
                    sample_d   = mem_q[rd_ptr_q];
                    step_cnt_d = '0;
                    state_d    = ST_RUN;
                end
            end else if (step) begin
                i1_d  = i1_new;
                bit_d = bit_new;
                ovf_d = sat_any;
`ifdef PDM_PCM_CONVERTER_SECOND_ORDER_EN
                i2_d  = i2_new;
`endif
                if (!last) begin
                    step_cnt_d = step_cnt_q + CW'(1);
                end else if (!fifo_empty) begin
                    sample_d   = mem_q[rd_ptr_q];
                    step_cnt_d = '0;
                end else begin
                    // Starved: integrators and bit register carry over to the next burst.
                    step_cnt_d = '0;
                    state_d    = ST_IDLE;
                    unf_d      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (push) mem_q[wr_ptr_q] <= pcm_data_i;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            sample_q   <= '0;
            step_cnt_q <= '0;
            i1_q       <= '0;
            bit_q      <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
`ifdef PDM_PCM_CONVERTER_SECOND_ORDER_EN
            i2_q       <= '0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            sample_q   <= sample_d;
            step_cnt_q <= step_cnt_d;
            i1_q       <= i1_d;
            bit_q      <= bit_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
`ifdef PDM_PCM_CONVERTER_SECOND_ORDER_EN
            i2_q       <= i2_d;
`endif
        end
    end
endmodule

// File: tb/tb_pcm_pdm_modulator.sv
// Bench for pcm_pdm_modulator: queue/integer reference model checked every cycle plus directed literal checks.
module tb_pcm_pdm_modulator;
    localparam int W = 16;
    localparam int R = 16;
    localparam int D = 4;
    localparam longint FS = longint'(1) <<< (W - 1);

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] pcm_data_i;
    logic         pcm_valid_i, pcm_ready_o, pdm_data_o, pdm_valid_o, pdm_ready_i;
    logic         enable_i, busy_o, overflow_o, underflow_o;

    int vecs = 0;
    int errs = 0;

    pcm_pdm_modulator #(
        .PDM_PCM_CONVERTER_DATA_WIDTH(W),
        .PDM_PCM_CONVERTER_INTERPOLATION_RATIO(R),
        .PDM_PCM_CONVERTER_FIFO_DEPTH(D)
    ) dut (
        .clock_i(clk), .reset_n_i(rst_n),
        .pcm_data_i(pcm_data_i), .pcm_valid_i(pcm_valid_i), .pcm_ready_o(pcm_ready_o),
        .pdm_data_o(pdm_data_o), .pdm_valid_o(pdm_valid_o), .pdm_ready_i(pdm_ready_i),
        .enable_i(enable_i), .busy_o(busy_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    always #5 clk = ~clk;

    // Reference model: the FIFO is a queue, the loop is plain integer arithmetic with clamping.
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_sample;
    longint       m_i1, m_i2;
    bit           m_bit, m_run, m_ovf, m_unf;
    int           m_cnt;

    function automatic longint clamp(input longint v, input int bits, output bit sat);
        longint lim;
        lim = longint'(1) <<< (bits - 1);
        sat = 1'b0;
        if (v > lim - 1) begin v = lim - 1; sat = 1'b1; end
        if (v < -lim)    begin v = -lim;    sat = 1'b1; end
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int sz0;
        bit pushv, s1, s2;
        longint x, fb;
        if (!rst_n || !enable_i) begin
            m_q.delete();
            m_sample = '0; m_i1 = 0; m_i2 = 0; m_bit = 0; m_run = 0; m_cnt = 0;
            m_ovf = 0; m_unf = 0;
        end else begin
            sz0   = m_q.size();
            pushv = pcm_valid_i && (sz0 < D);
            m_ovf = 0;
            m_unf = 0;
            if (!m_run) begin
                if (sz0 > 0) begin m_sample = m_q.pop_front(); m_run = 1; m_cnt = 0; end
            end else if (pdm_ready_i) begin
                x  = longint'($signed(m_sample));
                fb = m_bit ? FS : -FS;
                m_i1 = clamp(m_i1 + x - fb, W + 2, s1);
                s2 = 0;
`ifdef PDM_PCM_CONVERTER_SECOND_ORDER_EN
                m_i2  = clamp(m_i2 + m_i1 - fb, W + 4, s2);
                m_bit = (m_i2 >= 0);
`else
                m_bit = (m_i1 >= 0);
`endif
                m_ovf = s1 || s2;
                if (m_cnt == R - 1) begin
                    if (sz0 > 0) begin m_sample = m_q.pop_front(); m_cnt = 0; end
                    else begin m_run = 0; m_unf = 1; end
                end else begin
                    m_cnt++;
                end
            end
            if (pushv) m_q.push_back(pcm_data_i);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
        vecs++;
        if (act < lo || act > hi) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Every-cycle compare plus bookkeeping for the directed checks.
    bit bits_seen[$];
    int unf_cnt = 0, unf_bad = 0, ovf_cnt = 0;

    always @(negedge clk) begin
        chk("pdm_valid_o", longint'(pdm_valid_o), longint'(enable_i && m_run));
        chk("pcm_ready_o", longint'(pcm_ready_o), longint'(enable_i && (m_q.size() < D)));
        chk("pdm_data_o",  longint'(pdm_data_o),  longint'(m_bit));
        chk("busy_o",      longint'(busy_o),      longint'(m_run || (m_q.size() > 0)));
        chk("overflow_o",  longint'(overflow_o),  longint'(m_ovf));
        chk("underflow_o", longint'(underflow_o), longint'(m_unf));
        if (pdm_valid_o && pdm_ready_i) bits_seen.push_back(pdm_data_o);
        if (underflow_o) begin
            unf_cnt++;
            if (pdm_valid_o || busy_o) unf_bad++;
        end
        if (overflow_o) ovf_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        bits_seen.delete();
        unf_cnt = 0; unf_bad = 0; ovf_cnt = 0;
    endtask

    task automatic stream(input int n, input logic [W-1:0] val);
        int sent = 0;
        bit acc;
        pcm_data_i = val;
        for (int c = 0; c < 100 * n + 100 && sent < n; c++) begin
            pcm_valid_i = 1'b1;
            acc = pcm_ready_o;
            tick();
            if (acc) sent++;
        end
        pcm_valid_i = 1'b0;
        chk("stream_accepted", sent, n);
    endtask

    task automatic wait_idle(input int bound);
        bit done = 0;
        for (int c = 0; c < bound && !done; c++) begin
            if (!busy_o && !pdm_valid_o) done = 1;
            else tick();
        end
        chk("wait_idle_in_time", longint'(done), 1);
        repeat (2) tick();
    endtask

    function automatic int ones();
        int n = 0;
        foreach (bits_seen[i]) n += int'(bits_seen[i]);
        return n;
    endfunction

    task automatic chk_pattern();
        bit pat[7] = '{0, 1, 1, 0, 1, 0, 1};
        chk("pattern_len", bits_seen.size(), 256);
        for (int i = 0; i < 7; i++)
            if (i < bits_seen.size()) chk("pattern_bit", longint'(bits_seen[i]), longint'(pat[i]));
        chk_rng("pattern_ones", ones(), 126, 130);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc_n, hs;
        bit acc, ref_bit;
        rst_n = 1'b0; enable_i = 1'b0; pcm_valid_i = 1'b0; pcm_data_i = '0; pdm_ready_i = 1'b0;
        repeat (3) tick();
        chk("reset_valid", longint'(pdm_valid_o), 0);
        chk("reset_busy",  longint'(busy_o), 0);
        rst_n = 1'b1;
        tick();
        enable_i = 1'b1; pdm_ready_i = 1'b1;
        tick();

        // Latency: accept at edge T, first valid bit from T+1.
        clear_stats();
        pcm_data_i = '0; pcm_valid_i = 1'b1;
        tick();
        pcm_valid_i = 1'b0;
        chk("latency_T_valid", longint'(pdm_valid_o), 0);
        tick();
        chk("latency_T1_valid", longint'(pdm_valid_o), 1);
        stream(15, '0);
        wait_idle(400);
        chk_pattern();
        chk("zero_unf_once", unf_cnt, 1);

        // Three-quarter scale stream: 75% ones, no gaps, one final underflow.
        clear_stats();
        stream(64, 16'd16384);
        wait_idle(400);
        chk("dense_bits", bits_seen.size(), 1024);
        chk_rng("dense_ones", ones(), 758, 778);
        chk("dense_unf", unf_cnt, 1);

        // One sample then starvation.
        clear_stats();
        stream(1, 16'd1000);
        wait_idle(100);
        chk("starve_bits", bits_seen.size(), 16);
        chk("starve_unf", unf_cnt, 1);
        chk("starve_idle_at_unf", unf_bad, 0);

        // Consumer stalled: sample register plus four FIFO entries, then backpressure.
        pdm_ready_i = 1'b0; acc_n = 0;
        for (int i = 0; i < 10; i++) begin
            pcm_data_i  = W'(16'h0100 * i);
            pcm_valid_i = 1'b1;
            acc = pcm_ready_o;
            tick();
            if (acc) acc_n++;
        end
        chk("stall_accepted", acc_n, 5);
        chk("stall_pcm_ready", longint'(pcm_ready_o), 0);
        ref_bit = pdm_data_o;
        repeat (5) tick();
        chk("stall_data_stable", longint'(pdm_data_o), longint'(ref_bit));
        pdm_ready_i = 1'b1; hs = 0;
        for (int c = 0; c < 40 && !pcm_ready_o; c++) begin
            if (pdm_valid_o) hs++;
            tick();
        end
        pcm_valid_i = 1'b0;
        chk("stall_handshakes", hs, 16);
        wait_idle(200);

        // Enable dropped mid-run; re-enable must replay the post-reset pattern.
        stream(3, 16'd5000);
        repeat (10) tick();
        enable_i = 1'b0;
        #1;
        chk("disable_valid_same_cycle", longint'(pdm_valid_o), 0);
        tick();
        chk("disable_busy", longint'(busy_o), 0);
        chk("disable_pcm_ready", longint'(pcm_ready_o), 0);
        enable_i = 1'b1;
        tick();
        clear_stats();
        stream(16, '0);
        wait_idle(400);
        chk_pattern();

`ifdef PDM_PCM_CONVERTER_SECOND_ORDER_EN
        enable_i = 1'b0; tick(); enable_i = 1'b1; tick();
        clear_stats();
        stream(8, 16'h8000);
        wait_idle(300);
        chk_rng("neg_fs_ones", ones(), 0, 1);
        chk_rng("neg_fs_overflow", ovf_cnt, 1, 1000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
